// File: rtl/ecg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecg_pkg : shared widths, sample type and writer FSM states for the ECG LUT |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package ecg_pkg;

   localparam int ECG_DATA_W = 16;
   localparam int ECG_ADDR_W = 10;
   localparam int ECG_DEPTH  = 1024;

   typedef logic [ECG_DATA_W-1:0] ecg_sample_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } ecg_wr_state_e;

endpackage
`default_nettype wire

// File: rtl/ecg_lut_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecg_lut_writer_if : load control, sample stream and playback read bundle   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface ecg_lut_writer_if
   import ecg_pkg::*;
#(
   parameter int DATA_W = ECG_DATA_W,
   parameter int ADDR_W = ECG_ADDR_W
) ();

   logic              i_start;
   logic [ADDR_W:0]   i_len;
   logic              i_wr_valid;
   logic [DATA_W-1:0] i_wr_data;
   logic              o_wr_ready;
   logic              o_busy;
   logic              o_done;
   logic              o_err;
   logic [ADDR_W:0]   o_wr_count;
   logic [ADDR_W-1:0] i_rd_addr;
   logic [DATA_W-1:0] o_rd_data;

   modport master (
      output i_start, i_len, i_wr_valid, i_wr_data, i_rd_addr,
      input  o_wr_ready, o_busy, o_done, o_err, o_wr_count, o_rd_data
   );

   modport slave (
      input  i_start, i_len, i_wr_valid, i_wr_data, i_rd_addr,
      output o_wr_ready, o_busy, o_done, o_err, o_wr_count, o_rd_data
   );

endinterface
`default_nettype wire

// File: rtl/ecg_lut_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecg_lut_ram : simple dual-port RAM, registered read-first read port        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ecg_lut_ram
   import ecg_pkg::*;
#(
   parameter int DATA_W = ECG_DATA_W,
   parameter int ADDR_W = ECG_ADDR_W,
   parameter int DEPTH  = ECG_DEPTH
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   // Zero image at configuration; contents are never touched by reset.
   logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ecg_lut_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ecg_lut_writer : streams a waveform into the LUT, serves playback reads    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ecg_lut_writer
   import ecg_pkg::*;
#(
   parameter int DATA_W = ECG_DATA_W,
   parameter int ADDR_W = ECG_ADDR_W,
   parameter int DEPTH  = ECG_DEPTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   ecg_lut_writer_if.slave  bus
);

   localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

   ecg_wr_state_e     r_state;
   ecg_wr_state_e     w_state_nx;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_err;

   logic              w_len_ok;
   logic              w_start_en;
   logic              w_start_ok;
   logic              w_start_bad;
   logic              w_wr_fire;
   logic              w_last;
   logic              w_ready;
   logic              w_busy;
   logic              w_done;
   logic [DATA_W-1:0] w_rd_data;

   assign w_len_ok    = (bus.i_len != '0) && (bus.i_len <= c_depth);
   assign w_start_en  = bus.i_start && (r_state != DONE);
   assign w_start_ok  = w_start_en && w_len_ok;
   assign w_start_bad = w_start_en && !w_len_ok;
   // A start in the same cycle as a handshake wins; that sample is dropped.
   assign w_wr_fire   = (r_state == LOAD) && bus.i_wr_valid && !bus.i_start;
   assign w_last      = w_wr_fire && ((r_count + c_cnt_one) == r_len);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_ready    = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_state_nx = LOAD;
            end
         end
         LOAD: begin
            w_ready = 1'b1;
            w_busy  = 1'b1;
            if (w_start_en) begin
               w_state_nx = w_start_ok ? LOAD : IDLE;
            end else if (w_last) begin
               w_state_nx = DONE;
            end
         end
         DONE: begin
            w_done     = 1'b1;
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_len   <= '0;
         r_addr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (w_start_ok) begin
         r_len   <= bus.i_len;
         r_addr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_start_bad) begin
            r_err <= 1'b1;
         end
         if (w_wr_fire) begin
            r_addr  <= r_addr + c_addr_one;
            r_count <= r_count + c_cnt_one;
         end
      end
   end

   ecg_lut_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_wr_fire),
      .i_waddr (r_addr),
      .i_wdata (bus.i_wr_data),
      .i_raddr (bus.i_rd_addr),
      .o_rdata (w_rd_data)
   );

   assign bus.o_wr_ready = w_ready;
   assign bus.o_busy     = w_busy;
   assign bus.o_done     = w_done;
   assign bus.o_err      = r_err;
   assign bus.o_wr_count = r_count;
   assign bus.o_rd_data  = w_rd_data;

endmodule
`default_nettype wire

// File: doc/ecg_lut_writer.md
# ecg_lut_writer

Loads a 1024 × 16 ECG waveform table from a streaming sample source and serves it to the playback side through a registered read port. It is the write-side counterpart of the waveform lookup table: the host or DSP path streams samples in, and the playback address generator reads them back. This allows the waveform to change at run time without regenerating a memory image.

## Interface
- `DATA_W`, 16, sample width.
- `ADDR_W`, 10, table address width.
- `DEPTH`, 1024, table entries; must equal 2**ADDR_W.

- `i_clk`  in  1  single clock for all logic.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  one-cycle pulse that begins a load of `i_len` samples.
- `i_len`  in  ADDR_W+1  number of samples to load; legal range is 1..DEPTH.
- `i_wr_valid`  in  1  sample on `i_wr_data` is valid.
- `i_wr_data`  in  DATA_W  sample to write.
- `o_wr_ready`  out  1  block accepts a sample this cycle.
- `o_busy`  out  1  a load is in progress.
- `o_done`  out  1  one-cycle pulse after the last sample is written.
- `o_err`  out  1  sticky flag; set when `i_start` arrives with an illegal `i_len`.
- `o_wr_count`  out  ADDR_W+1  number of samples written in the current or last load.
- `i_rd_addr`  in  ADDR_W  playback read address.
- `o_rd_data`  out  DATA_W  table word at the registered address.

## Operation
- FSM states are IDLE, LOAD and DONE. Reset sends the FSM to IDLE.
- **IDLE**
  - `o_wr_ready` is 0.
  - `i_start` with 1 ≤ `i_len` ≤ DEPTH: latch `i_len`, clear the write address and `o_wr_count`, clear `o_err`, go to LOAD.
  - `i_start` with `i_len` = 0 or `i_len` > DEPTH: set `o_err` and stay in IDLE. The table is untouched.
- **LOAD**
  - `o_wr_ready` = 1 and `o_busy` = 1.
  - When `i_wr_valid` & `o_wr_ready`: write `mem[addr]` = `i_wr_data`, increment `addr`, increment `o_wr_count`.
  - The handshake that writes address `len`-1 moves the FSM to DONE.
- **DONE**
  - Lasts one cycle with `o_done` = 1, `o_wr_ready` = 0 and `o_busy` = 0, then returns to IDLE.
- **`i_start` during LOAD:** aborts the current load and applies the IDLE rules. A legal length restarts at address 0 the next cycle. An illegal length sets `o_err` and returns to IDLE. Any write handshake in that same cycle is discarded, and already-written entries keep their new values.
- **`i_start` during DONE:** ignored.
- **Unwritten entries:** entries at or above `i_len` keep their previous contents.
- **Address width:** the write address never exceeds DEPTH-1, so no wrap-around is possible.
- **Read port:**
  - Always active, independent of the FSM.
  - `o_rd_data` = `mem[i_rd_addr]` registered.
  - A read and write to the same address in the same cycle returns the old data (read-first).
- **Memory initialisation and reset:** the memory is initialised to all zeros at configuration. It is not cleared by `i_rst`; contents survive reset.

## Timing
- **Reset values:** `o_wr_ready` = 0, `o_busy` = 0, `o_done` = 0, `o_err` = 0, `o_wr_count` = 0, `o_rd_data` = 0.
- **Start latency:** `i_start` in cycle N gives `o_wr_ready` = 1 in cycle N+1.
- **Write latency:** a write handshake in cycle N is visible on the read port when `i_rd_addr` is presented in cycle N+1 (data out in cycle N+2).
- **Read latency:** 1 cycle from `i_rd_addr` to `o_rd_data`.
- **Done pulse:** the last handshake in cycle N gives `o_done` = 1 in cycle N+1 only.
- **Throughput:** one sample per cycle at sustained `i_wr_valid`.
- **Back-pressure:** `o_wr_ready` depends only on state, never on `i_wr_valid`. There is no combinational path from input to `o_wr_ready`.
- **Reset mid-load:** reset returns the FSM to IDLE in the next cycle. A partially written table is retained and `o_done` is not asserted.

## Structure
- Package `ecg_pkg`:
  - `ECG_DATA_W` = 16, `ECG_ADDR_W` = 10, `ECG_DEPTH` = 1024.
  - Typedef `ecg_sample_t` (logic [15:0]).
  - Enum `ecg_wr_state_e` {IDLE, LOAD, DONE}.
- Sub-module `ecg_lut_ram`: simple dual-port RAM, one write port and one registered read port, read-first, zero-initialised. It infers block RAM.
- Top level: FSM, address/count registers and error flag.

## Test plan
- **Full load:** reset, then `i_start` with `i_len` = 1024, then stream `data` = addr ^ 16'hA5A5 with continuous valid.
  - `o_done` pulses exactly 1025 cycles after `i_start` (1 cycle to LOAD + 1024 handshakes).
  - `o_wr_count` = 1024.
  - Reading every address returns addr ^ 16'hA5A5 with 1-cycle latency.
- **Partial load with gaps:** `i_len` = 3, samples 16'h0011, 16'h0022, 16'h0033, with `i_wr_valid` deasserted for 2 cycles between samples.
  - Addresses 0..2 hold the new values.
  - Address 3 keeps its prior value.
  - `o_done` appears one cycle after the third handshake.
- **Illegal length:** `i_start` with `i_len` = 0, then `i_start` with `i_len` = 1025.
  - `o_err` = 1, the FSM stays in IDLE, `o_wr_ready` stays 0 and memory is unchanged.
  - A following legal `i_start` clears `o_err`.
- **Restart mid-load:** `i_len` = 8, write 4 samples, then `i_start` with `i_len` = 2 while `i_wr_valid` = 1.
  - The sample in the restart cycle is dropped.
  - The next 2 samples land at addresses 0 and 1.
  - `o_done` fires once, and `o_wr_count` = 2.
- **Read/write collision:** `i_rd_addr` = 5 in the same cycle that address 5 is written with 16'hBEEF.
  - `o_rd_data` shows the old value.
  - The next read of address 5 returns 16'hBEEF.
- **Reset mid-load:** assert `i_rst` after 10 of 20 samples.
  - All outputs go to their reset values the next cycle and `o_done` never fires.
  - Addresses 0..9 keep the written data.
